encoder43: RTL and testbench

ENCODER43 -- requirements
Module: encoder43

---
 rtl/encoder43_pkg.sv | 6 +
 rtl/encoder43_expression.sv | 15 +
 rtl/encoder43_gates.sv | 24 ++
 rtl/encoder43_table.sv | 39 +++
 rtl/encoder43.sv | 53 +++++
 tb/tb_encoder43.sv | 104 ++++++++++
 6 files changed

// File: rtl/encoder43_pkg.sv
// Shared width and count type for the three popcount implementations
// and the top-level register stage.
package encoder43_pkg;
  localparam int Y_W = 3;
  typedef logic [Y_W-1:0] count_t;
endpackage

// File: rtl/encoder43_expression.sv
// Popcount of four bits written as continuous Boolean expressions.
module encoder43_expression (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y2,
  output logic y1,
  output logic y0
);
  assign y0 = a ^ b ^ c ^ d;
  assign y2 = a & b & c & d;
  // bit 1 is set for two or three ones, cleared again for all four
  assign y1 = ((a & b) | (c & d) | ((a ^ b) & (c ^ d))) & ~(a & b & c & d);
endmodule

// File: rtl/encoder43_gates.sv
// Popcount of four bits built from primitive gates only:
// two half adders feeding a 2-bit adder.
module encoder43_gates (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y2,
  output logic y1,
  output logic y0
);
  logic sum_ab, carry_ab, sum_cd, carry_cd, carry_mid;

  xor g_sum_ab   (sum_ab,   a, b);
  and g_carry_ab (carry_ab, a, b);
  xor g_sum_cd   (sum_cd,   c, d);
  and g_carry_cd (carry_cd, c, d);

  // carry_mid is mutually exclusive with either pair carry, so XOR is safe for bit 1
  and g_carry_mid (carry_mid, sum_ab, sum_cd);
  xor g_y0 (y0, sum_ab, sum_cd);
  xor g_y1 (y1, carry_ab, carry_cd, carry_mid);
  and g_y2 (y2, carry_ab, carry_cd);
endmodule

// File: rtl/encoder43_table.sv
// Popcount of four bits as an explicit 16-entry truth table.
module encoder43_table
  import encoder43_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y2,
  output logic y1,
  output logic y0
);
  count_t y;

  always_comb begin
    y = 3'b000;
    case ({a, b, c, d})
      4'b0000: y = 3'b000;
      4'b0001: y = 3'b001;
      4'b0010: y = 3'b001;
      4'b0011: y = 3'b010;
      4'b0100: y = 3'b001;
      4'b0101: y = 3'b010;
      4'b0110: y = 3'b010;
      4'b0111: y = 3'b011;
      4'b1000: y = 3'b001;
      4'b1001: y = 3'b010;
      4'b1010: y = 3'b010;
      4'b1011: y = 3'b011;
      4'b1100: y = 3'b010;
      4'b1101: y = 3'b011;
      4'b1110: y = 3'b011;
      4'b1111: y = 3'b100;
      default: y = 3'b000;
    endcase
  end

  assign {y2, y1, y0} = y;
endmodule

// File: rtl/encoder43.sv
// Registers three independent popcount implementations side by side
// and flags any disagreement between them.
module encoder43
  import encoder43_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   a,
  input  logic   b,
  input  logic   c,
  input  logic   d,
  output count_t y_gates,
  output count_t y_expression,
  output count_t y_table,
  output logic   mismatch
);
  count_t gates_y, expression_y, table_y;
  logic   differ;

  encoder43_gates u_gates (
    .a(a), .b(b), .c(c), .d(d),
    .y2(gates_y[2]), .y1(gates_y[1]), .y0(gates_y[0])
  );

  encoder43_expression u_expression (
    .a(a), .b(b), .c(c), .d(d),
    .y2(expression_y[2]), .y1(expression_y[1]), .y0(expression_y[0])
  );

  encoder43_table u_table (
    .a(a), .b(b), .c(c), .d(d),
    .y2(table_y[2]), .y1(table_y[1]), .y0(table_y[0])
  );

  // any pairwise difference implies the three are not all equal
  assign differ = CHECK_EN && ((gates_y != expression_y) || (expression_y != table_y));

  always_ff @(posedge clk) begin
    if (reset) begin
      y_gates      <= '0;
      y_expression <= '0;
      y_table      <= '0;
      mismatch     <= 1'b0;
    end else begin
      y_gates      <= gates_y;
      y_expression <= expression_y;
      y_table      <= table_y;
      mismatch     <= differ;
    end
  end
endmodule

// File: tb/tb_encoder43.sv
// Directed checks of encoder43: reset, full sweep, back-to-back,
// mid-stream reset and forced disagreement with the checker on and off.
module tb_encoder43;
  import encoder43_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  count_t y_gates, y_expression, y_table;
  logic   mismatch;
  count_t n_y_gates, n_y_expression, n_y_table;
  logic   n_mismatch;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0] expected_count [16];

  encoder43 #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .y_gates(y_gates), .y_expression(y_expression), .y_table(y_table),
    .mismatch(mismatch)
  );

  encoder43 #(.CHECK_EN(1'b0)) dut_nochk (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .y_gates(n_y_gates), .y_expression(n_y_expression), .y_table(n_y_table),
    .mismatch(n_mismatch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // drive inputs, then sample just after the capturing edge
  task automatic applyStimulus(input logic [3:0] v);
    {a, b, c, d} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [2:0] exp_y, input logic exp_mis);
    checkOutput({tag, " y_gates"},      {1'b0, y_gates},      {1'b0, exp_y});
    checkOutput({tag, " y_expression"}, {1'b0, y_expression}, {1'b0, exp_y});
    checkOutput({tag, " y_table"},      {1'b0, y_table},      {1'b0, exp_y});
    checkOutput({tag, " mismatch"},     {3'b0, mismatch},     {3'b0, exp_mis});
    checkOutput({tag, " nochk y_table"},  {1'b0, n_y_table},  {1'b0, exp_y});
    checkOutput({tag, " nochk mismatch"}, {3'b0, n_mismatch}, 4'b0000);
  endtask

  initial begin
    expected_count = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
                       3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4};

    reset = 1'b1;
    applyStimulus(4'b1111);
    checkAll("reset1", 3'b000, 1'b0);
    applyStimulus(4'b1111);
    checkAll("reset2", 3'b000, 1'b0);

    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i));
      checkAll($sformatf("sweep %b", 4'(i)), expected_count[i], 1'b0);
    end

    applyStimulus(4'b0000);
    checkAll("b2b 0000", 3'b000, 1'b0);
    applyStimulus(4'b1111);
    checkAll("b2b 1111", 3'b100, 1'b0);
    applyStimulus(4'b0000);
    checkAll("b2b 0000b", 3'b000, 1'b0);

    applyStimulus(4'b1011);
    checkAll("pre-reset 1011", 3'b011, 1'b0);
    reset = 1'b1;
    applyStimulus(4'b1110);
    checkAll("mid reset", 3'b000, 1'b0);
    reset = 1'b0;
    applyStimulus(4'b1110);
    checkAll("after reset", 3'b011, 1'b0);

    force dut.table_y = 3'b111;
    force dut_nochk.table_y = 3'b111;
    applyStimulus(4'b0001);
    checkOutput("fault y_table",        {1'b0, y_table},   4'b0111);
    checkOutput("fault y_gates",        {1'b0, y_gates},   4'b0001);
    checkOutput("fault mismatch",       {3'b0, mismatch},  4'b0001);
    checkOutput("fault nochk mismatch", {3'b0, n_mismatch}, 4'b0000);
    release dut.table_y;
    release dut_nochk.table_y;
    applyStimulus(4'b0001);
    checkAll("fault cleared", 3'b001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
